// File: rtl/ext_mem_harness.sv
// ext_mem_harness: external memory model and result checker for the 4-bit CPU pin bus.
// The program is preloaded through the load port, then the CPU runs against the RAM.
// The run ends when the sentinel address is held long enough, or when the cycle budget
// runs out. After that, expected (addr, data) vectors are streamed in and compared.
// Optional macro RO_GUARD_EN: in RUN, CPU writes below RO_LIMIT are blocked and counted.
module ext_mem_harness #(
  parameter int                DATA_W     = 4,
  parameter int                ADDR_W     = 11,
  parameter logic [ADDR_W-1:0] DONE_ADDR  = '1,
  parameter int                DONE_HOLD  = 1,
  parameter int                MAX_CYCLES = 65535,
  parameter int                CNT_W      = 16,
  parameter int                RO_LIMIT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              chk_valid,
  output logic              chk_ready,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              chk_last,
  output logic [1:0]        state_o,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              pass,
  output logic [CNT_W-1:0]  ro_viol
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_TARGET = CNT_W'(DONE_HOLD);
  localparam logic [CNT_W-1:0] CYCLE_LIMIT = CNT_W'(MAX_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  ro_q, ro_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_blocked;
  logic              chk_miss;

`ifdef RO_GUARD_EN
  assign wr_blocked = (32'(cpu_addr) < $unsigned(RO_LIMIT));
`else
  assign wr_blocked = 1'b0;
`endif

  // Next-state, counter updates, RAM write port selection and bus outputs
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    hold_d      = hold_q;
    err_d       = err_q;
    ro_d        = ro_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    mem_we      = 1'b0;
    mem_waddr   = ld_addr;
    mem_wdata   = ld_data;
    cpu_rdata   = '0;
    chk_ready   = 1'b0;
    chk_miss    = (mem[chk_addr] != chk_data);
    unique case (state_q)
      ST_LOAD: begin
        mem_we = ld_en;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!cpu_rw) cpu_rdata = mem[cpu_addr];
        if (cpu_rw) begin
          if (wr_blocked) begin
            if (ro_q != '1) ro_d = ro_q + 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = cpu_addr;
            mem_wdata = cpu_wdata;
          end
        end
        cycle_d = cycle_q + 1'b1;
        hold_d  = (cpu_addr == DONE_ADDR) ? hold_q + 1'b1 : '0;
        if (hold_d == HOLD_TARGET) state_d = ST_CHECK;
        if (cycle_d == CYCLE_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        chk_ready = 1'b1;
        if (chk_valid) begin
          if (chk_miss) begin
            if (err_q == '0) first_err_d = chk_addr;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          if (chk_last) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0) && !timeout_q && (ro_q == '0);
          end
        end
      end
      ST_DONE: begin
      end
    endcase
  end

  // Control and status registers; the RAM itself is not cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cycle_q     <= '0;
      hold_q      <= '0;
      err_q       <= '0;
      ro_q        <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      ro_q        <= ro_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  // Single RAM write port; a write pending in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign state_o        = state_q;
  assign timeout        = timeout_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;
  assign pass           = pass_q;
  assign ro_viol        = ro_q;

endmodule
